// File: rtl/generic_fifo_sc_p.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow and selectable first-word-fall-through read mode.
module generic_fifo_sc_p #(
  parameter int DW   = 153,
  parameter int AW   = 4,
  parameter int AF_N = 2,
  parameter int AE_N = 2,
  parameter int FWFT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          we,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL   = (AW+1)'(DEPTH - AF_N);
  localparam logic [AW:0] AE_LVL   = (AW+1)'(AE_N);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wp_r;
  logic [AW-1:0] rp_r;
  logic [AW-1:0] rp_inc_s;
  logic [AW:0]   count_r;
  logic [AW:0]   count_nx_s;
  logic          rd_ok_s;
  logic          wr_ok_s;
  logic          mem_we_s;
  logic [DW-1:0] dout_r;
  logic [DW-1:0] dout_nx_s;
  logic          full_r;
  logic          empty_r;
  logic          af_r;
  logic          ae_r;
  logic          ovf_r;
  logic          unf_r;

  // Request acceptance, next occupancy and next value of the output data register.
  always_comb begin
    rd_ok_s    = re & ~empty_r;
    wr_ok_s    = we & (~full_r | rd_ok_s);
    mem_we_s   = wr_ok_s & rst & ~clr;
    rp_inc_s   = rp_r + AW'(1);
    count_nx_s = count_r + (AW+1)'(wr_ok_s) - (AW+1)'(rd_ok_s);
    dout_nx_s  = dout_r;
    if (FWFT != 0) begin
      // Head lookahead: after a pop the new head is the next slot, or the
      // incoming word when the last entry leaves in the same cycle.
      if (rd_ok_s) begin
        if (count_r == ONE_LVL) begin
          if (wr_ok_s) begin
            dout_nx_s = din;
          end else begin
            dout_nx_s = dout_r;
          end
        end else begin
          dout_nx_s = mem_r[rp_inc_s];
        end
      end else if (empty_r && wr_ok_s) begin
        dout_nx_s = din;
      end else begin
        dout_nx_s = dout_r;
      end
    end else begin
      if (rd_ok_s) begin
        dout_nx_s = mem_r[rp_r];
      end else begin
        dout_nx_s = dout_r;
      end
    end
  end

  // Pointers, occupancy, status flags and output data register.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      wp_r    <= '0;
      rp_r    <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
      dout_r  <= '0;
    end else begin
      if (wr_ok_s) begin
        wp_r <= wp_r + AW'(1);
      end
      if (rd_ok_s) begin
        rp_r <= rp_inc_s;
      end
      count_r <= count_nx_s;
      full_r  <= (count_nx_s == FULL_LVL);
      empty_r <= (count_nx_s == '0);
      af_r    <= (count_nx_s >= AF_LVL);
      ae_r    <= (count_nx_s <= AE_LVL);
      ovf_r   <= ovf_r | (we & ~wr_ok_s);
      unf_r   <= unf_r | (re & ~rd_ok_s);
      dout_r  <= dout_nx_s;
    end
  end

  // Storage array; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[wp_r] <= din;
    end
  end

  assign dout         = dout_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = af_r;
  assign almost_empty = ae_r;
  assign count        = count_r;
  assign overflow     = ovf_r;
  assign underflow    = unf_r;

endmodule

// File: tb/tb_generic_fifo_sc_p.sv
// Scoreboard bench for generic_fifo_sc_p: one FWFT=1 and one FWFT=0 instance driven in lockstep.
module tb_generic_fifo_sc_p;

  logic       clk = 1'b0;
  logic       rst, clr, we, re;
  logic [7:0] din;
  logic [7:0] dout1, dout0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic [2:0] count1, count0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] mq[$];
  logic [7:0] exp1[$];
  logic [7:0] exp0[$];
  logic       m_ovf, m_unf;
  logic       pend0 = 1'b0;

  always #5 clk = ~clk;

  generic_fifo_sc_p #(.DW(8), .AW(2), .AF_N(1), .AE_N(1), .FWFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .re(re), .dout(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(unf1));

  generic_fifo_sc_p #(.DW(8), .AW(2), .AF_N(1), .AE_N(1), .FWFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .re(re), .dout(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(unf0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; the model queue predicts acceptance and feeds the scoreboard.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
    logic rd, wr;
    logic [7:0] v;
    logic [8:0] ev;
    we = w; re = r; din = d; clr = c;
    if (!rst || c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rd = r && (mq.size() != 0);
      wr = w && ((mq.size() < 4) || rd);
      if (rd) begin
        v = mq.pop_front();
        exp1.push_back(v);
        exp0.push_back(v);
      end
      if (wr) mq.push_back(d);
      if (w && !wr) m_ovf = 1'b1;
      if (r && !rd) m_unf = 1'b1;
    end
    @(posedge clk);
    #2;
    ev = {3'(mq.size()), mq.size() == 4, mq.size() == 0, mq.size() >= 3,
          mq.size() <= 1, m_ovf, m_unf};
    chk("flags_fwft1", {count1, full1, empty1, af1, ae1, ovf1, unf1}, 32'(ev));
    chk("flags_fwft0", {count0, full0, empty0, af0, ae0, ovf0, unf0}, 32'(ev));
  endtask

  // FWFT=1 monitor: the head is on dout during the cycle in which it is popped.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst && !clr && re && !empty1) begin
      if (exp1.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL rd_fwft1: unexpected pop, dout %0h", dout1);
      end else begin
        e = exp1.pop_front();
        chk("rd_fwft1", 32'(dout1), 32'(e));
      end
    end
  end

  // FWFT=0 monitor: data appears on dout the cycle after the accepted pop.
  always @(negedge clk) begin
    logic [7:0] e;
    if (pend0) begin
      if (exp0.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL rd_fwft0: unexpected pop, dout %0h", dout0);
      end else begin
        e = exp0.pop_front();
        chk("rd_fwft0", 32'(dout0), 32'(e));
      end
    end
    pend0 <= rst && !clr && re && !empty0;
  end

  initial begin
    logic [7:0] fill[4];
    logic       w, r;
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
    rst = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0; din = 8'h00;
    m_ovf = 1'b0; m_unf = 1'b0;

    step(1'b1, 1'b1, 8'hEE, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    chk("rst_dout1", 32'(dout1), 32'h0);
    chk("rst_dout0", 32'(dout0), 32'h0);
    chk("rst_empty", {empty1, ae1, full1, af1}, 32'b1100);

    // Fill and drain
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, fill[i], 1'b0);
      chk("fill_count", 32'(count1), 32'(i + 1));
      if (i == 0) chk("fwft_bypass", 32'(dout1), 32'h11);
      if (i == 1) chk("ae_drop", 32'(ae1), 32'h0);
      if (i == 1) chk("af_low", 32'(af1), 32'h0);
      if (i == 2) chk("af_rise", 32'(af1), 32'h1);
      if (i == 2) chk("full_low", 32'(full1), 32'h0);
      if (i == 3) chk("full_rise", 32'(full1), 32'h1);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("drain_empty", {empty1, empty0}, 32'b11);

    // Overflow
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, fill[i], 1'b0);
    step(1'b1, 1'b0, 8'h55, 1'b0);
    chk("ovf_count", 32'(count1), 32'h4);
    chk("ovf_set", {ovf1, ovf0}, 32'b11);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ovf_sticky", {ovf1, ovf0}, 32'b11);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ovf_drained", 32'(exp1.size() + exp0.size()), 32'h0);

    // Full bypass
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_ovf", {ovf1, ovf0}, 32'b00);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, fill[i], 1'b0);
    step(1'b1, 1'b1, 8'h66, 1'b0);
    chk("byp_state", {count1, full1, ovf1}, 32'b100_1_0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // Empty read with simultaneous write
    step(1'b1, 1'b1, 8'h77, 1'b0);
    chk("unf_state", {count1, unf1, unf0}, 32'b001_1_1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("empty_rd_dout1", 32'(dout1), 32'h77);
    step(1'b0, 1'b1, 8'h00, 1'b0);

    // Wrap-around with random legal traffic
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (mq.size() == 0) r = 1'b0;
      if (mq.size() == 4 && !r) w = 1'b0;
      step(w, r, 8'($urandom_range(0, 255)), 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, mq.size() != 0, 8'h00, 1'b0);
    chk("wrap_errs", {ovf1, unf1, ovf0, unf0}, 32'h0);

    // Clear mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, fill[i], 1'b0);
    step(1'b1, 1'b0, 8'h99, 1'b1);
    chk("clr_state", {count1, empty1, ovf1, unf1}, 32'b000_1_0_0);
    chk("clr_state0", {count0, empty0, ovf0, unf0}, 32'b000_1_0_0);
    step(1'b1, 1'b0, 8'hA1, 1'b0);
    chk("clr_push_dout1", 32'(dout1), 32'hA1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("sb_drained", 32'(exp1.size() + exp0.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
